// File: rtl/gate_sweep_if.sv
// Sweeper <-> gate-under-test bundle: start control, stimulus vector, gate response, sweep status.
// master = sweeper side, slave = bench/gate side.
interface gate_sweep_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] stim;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] fail_vec;

    modport master (
        input  start, dut_out,
        output stim, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, dut_out,
        input  stim, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_sweep.sv
// Exhaustive clocked truth-table sweeper for a single-output combinational gate.
// Optional GATE_SWEEP_STOP_EN: stop at the first mismatching vector instead of sweeping all.
module gate_sweep #(
    parameter int                  N_IN   = 2,
    parameter int                  HOLD   = 1,
    parameter logic [2**N_IN-1:0]  EXP_TT = 4'b0111
) (
    input  logic          clock,
    input  logic          reset,
    gate_sweep_if.master  bus
);
    localparam int             HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [N_IN-1:0] r_stim;
    logic [HW-1:0]   r_hold;
    logic [N_IN:0]   r_err;
    logic [N_IN-1:0] r_fail;
    logic            r_flag;

    logic w_mismatch;
    logic w_last;
    logic w_done;

    assign w_mismatch = (bus.dut_out != EXP_TT[r_stim]);
    assign w_last     = (r_stim == {N_IN{1'b1}});
    assign w_done     = (r_state == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_stim  <= '0;
            r_hold  <= '0;
            r_err   <= '0;
            r_fail  <= '0;
            r_flag  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_stim  <= '0;
                        r_hold  <= '0;
                        r_err   <= '0;
                        r_fail  <= '0;
                        r_flag  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_hold < HOLD_LAST) begin
                        r_hold <= r_hold + 1'b1;
                    end else begin
                        if (w_mismatch) begin
                            r_err <= r_err + 1'b1;
                            if (!r_flag) begin
                                r_fail <= r_stim;
                                r_flag <= 1'b1;
                            end
                        end
`ifdef GATE_SWEEP_STOP_EN
                        if (w_mismatch || w_last) begin
`else
                        if (w_last) begin
`endif
                            r_state <= S_DONE;
                        end else begin
                            r_stim <= r_stim + 1'b1;
                            r_hold <= '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Status decodes straight from the state register, so busy/done are mutually exclusive.
    assign bus.stim      = r_stim;
    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = w_done;
    assign bus.pass      = w_done && (r_err == '0);
    assign bus.err_count = r_err;
    assign bus.fail_vec  = r_fail;
endmodule

// File: tb/tb_gate_sweep.sv
// Directed bench for gate_sweep: a 2-input instance with selectable gate models and a 3-input HOLD=3 instance.
module tb_gate_sweep;
    localparam int M_NAND  = 0;
    localparam int M_STUCK = 1;
    localparam int M_AND   = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   mode_a = M_NAND;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    gate_sweep_if #(.N_IN(2)) bus_a ();
    gate_sweep_if #(.N_IN(3)) bus_b ();

    gate_sweep #(.N_IN(2), .HOLD(1), .EXP_TT(4'b0111)) u_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.master)
    );

    gate_sweep #(.N_IN(3), .HOLD(3), .EXP_TT(8'b1000_0000)) u_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.master)
    );

    always_comb begin
        case (mode_a)
            M_STUCK: bus_a.dut_out = 1'b1;
            M_AND:   bus_a.dut_out = &bus_a.stim;
            default: bus_a.dut_out = ~&bus_a.stim;
        endcase
    end
    assign bus_b.dut_out = &bus_b.stim;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.pass !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b done=%b pass=%b exp 0 0 0", bus_a.busy, bus_a.done, bus_a.pass);
        end
        checks++;
        if (bus_a.stim !== 2'd0 || bus_a.err_count !== 3'd0 || bus_a.fail_vec !== 2'd0) begin
            failures++;
            $display("FAIL reset_regs got stim=%0d err=%0d fv=%0d exp 0 0 0", bus_a.stim, bus_a.err_count, bus_a.fail_vec);
        end
        checks++;
        if (bus_b.busy !== 1'b0 || bus_b.done !== 1'b0 || bus_b.stim !== 3'd0) begin
            failures++;
            $display("FAIL reset_b got busy=%b done=%b stim=%0d exp 0 0 0", bus_b.busy, bus_b.done, bus_b.stim);
        end
    endtask

    task automatic test_nand();
        mode_a = M_NAND;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.stim !== 2'd0) begin
            failures++;
            $display("FAIL nand_start got busy=%b stim=%0d exp 1 0", bus_a.busy, bus_a.stim);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (bus_a.stim !== 2'(i) || bus_a.done !== 1'b0 || bus_a.busy !== 1'b1) begin
                failures++;
                $display("FAIL nand_step%0d got stim=%0d done=%b busy=%b exp %0d 0 1", i, bus_a.stim, bus_a.done, bus_a.busy, i);
            end
        end
        tick();
        checks++;
        if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.pass !== 1'b1) begin
            failures++;
            $display("FAIL nand_done got done=%b busy=%b pass=%b exp 1 0 1", bus_a.done, bus_a.busy, bus_a.pass);
        end
        checks++;
        if (bus_a.err_count !== 3'd0 || bus_a.fail_vec !== 2'd0 || bus_a.stim !== 2'd3) begin
            failures++;
            $display("FAIL nand_result got err=%0d fv=%0d stim=%0d exp 0 0 3", bus_a.err_count, bus_a.fail_vec, bus_a.stim);
        end
        tick();
        checks++;
        if (bus_a.done !== 1'b1 || bus_a.stim !== 2'd3) begin
            failures++;
            $display("FAIL nand_frozen got done=%b stim=%0d exp 1 3", bus_a.done, bus_a.stim);
        end
    endtask

    task automatic test_start_in_run();
        mode_a = M_NAND;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick();
        tick();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.stim !== 2'd3 || bus_a.busy !== 1'b1) begin
            failures++;
            $display("FAIL run_start_ignored got stim=%0d busy=%b exp 3 1", bus_a.stim, bus_a.busy);
        end
        tick();
        checks++;
        if (bus_a.done !== 1'b1 || bus_a.pass !== 1'b1) begin
            failures++;
            $display("FAIL run_start_done got done=%b pass=%b exp 1 1", bus_a.done, bus_a.pass);
        end
    endtask

    task automatic test_start_held();
        mode_a = M_NAND;
        bus_a.start = 1'b1;
        tick();
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.stim !== 2'd0) begin
            failures++;
            $display("FAIL held_run1 got busy=%b stim=%0d exp 1 0", bus_a.busy, bus_a.stim);
        end
        repeat (4) tick();
        checks++;
        if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0) begin
            failures++;
            $display("FAIL held_done1 got done=%b busy=%b exp 1 0", bus_a.done, bus_a.busy);
        end
        tick();
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.done !== 1'b0 || bus_a.stim !== 2'd0) begin
            failures++;
            $display("FAIL held_run2 got busy=%b done=%b stim=%0d exp 1 0 0", bus_a.busy, bus_a.done, bus_a.stim);
        end
        bus_a.start = 1'b0;
        repeat (4) tick();
        checks++;
        if (bus_a.done !== 1'b1 || bus_a.pass !== 1'b1) begin
            failures++;
            $display("FAIL held_done2 got done=%b pass=%b exp 1 1", bus_a.done, bus_a.pass);
        end
    endtask

    task automatic test_stuck1();
        mode_a = M_STUCK;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus_a.done !== 1'b0 || bus_a.err_count !== 3'd0) begin
            failures++;
            $display("FAIL stuck_pre got done=%b err=%0d exp 0 0", bus_a.done, bus_a.err_count);
        end
        tick();
        checks++;
        if (bus_a.done !== 1'b1 || bus_a.pass !== 1'b0 || bus_a.err_count !== 3'd1 || bus_a.fail_vec !== 2'd3) begin
            failures++;
            $display("FAIL stuck_done got done=%b pass=%b err=%0d fv=%0d exp 1 0 1 3",
                     bus_a.done, bus_a.pass, bus_a.err_count, bus_a.fail_vec);
        end
    endtask

    task automatic test_and();
        mode_a = M_AND;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.err_count !== 3'd0 || bus_a.fail_vec !== 2'd0 || bus_a.busy !== 1'b1) begin
            failures++;
            $display("FAIL and_restart got err=%0d fv=%0d busy=%b exp 0 0 1", bus_a.err_count, bus_a.fail_vec, bus_a.busy);
        end
        tick();
`ifdef GATE_SWEEP_STOP_EN
        checks++;
        if (bus_a.done !== 1'b1 || bus_a.stim !== 2'd0 || bus_a.err_count !== 3'd1 ||
            bus_a.fail_vec !== 2'd0 || bus_a.pass !== 1'b0) begin
            failures++;
            $display("FAIL and_stop got done=%b stim=%0d err=%0d fv=%0d pass=%b exp 1 0 1 0 0",
                     bus_a.done, bus_a.stim, bus_a.err_count, bus_a.fail_vec, bus_a.pass);
        end
`else
        repeat (3) tick();
        checks++;
        if (bus_a.done !== 1'b1 || bus_a.err_count !== 3'd4 || bus_a.fail_vec !== 2'd0 || bus_a.pass !== 1'b0) begin
            failures++;
            $display("FAIL and_full got done=%b err=%0d fv=%0d pass=%b exp 1 4 0 0",
                     bus_a.done, bus_a.err_count, bus_a.fail_vec, bus_a.pass);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        mode_a = M_AND;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick();
        tick();
`ifndef GATE_SWEEP_STOP_EN
        checks++;
        if (bus_a.err_count !== 3'd2 || bus_a.stim !== 2'd2 || bus_a.busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre got err=%0d stim=%0d busy=%b exp 2 2 1", bus_a.err_count, bus_a.stim, bus_a.busy);
        end
`endif
        reset = 1'b1;
        bus_a.start = 1'b1;
        tick();
        reset = 1'b0;
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.stim !== 2'd0 ||
            bus_a.err_count !== 3'd0 || bus_a.fail_vec !== 2'd0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%b done=%b stim=%0d err=%0d fv=%0d exp 0 0 0 0 0",
                     bus_a.busy, bus_a.done, bus_a.stim, bus_a.err_count, bus_a.fail_vec);
        end
        tick();
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
            failures++;
            $display("FAIL midrun_idle got busy=%b done=%b exp 0 0", bus_a.busy, bus_a.done);
        end
    endtask

    task automatic test_wide_hold();
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        checks++;
        if (bus_b.busy !== 1'b1 || bus_b.stim !== 3'd0) begin
            failures++;
            $display("FAIL wide_start got busy=%b stim=%0d exp 1 0", bus_b.busy, bus_b.stim);
        end
        for (int t = 1; t < 24; t++) begin
            tick();
            checks++;
            if (bus_b.stim !== 3'(t / 3) || bus_b.done !== 1'b0) begin
                failures++;
                $display("FAIL wide_hold_t%0d got stim=%0d done=%b exp %0d 0", t, bus_b.stim, bus_b.done, t / 3);
            end
        end
        tick();
        checks++;
        if (bus_b.done !== 1'b1 || bus_b.pass !== 1'b1 || bus_b.stim !== 3'd7 || bus_b.err_count !== 4'd0) begin
            failures++;
            $display("FAIL wide_done got done=%b pass=%b stim=%0d err=%0d exp 1 1 7 0",
                     bus_b.done, bus_b.pass, bus_b.stim, bus_b.err_count);
        end
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        test_reset();
        test_nand();
        test_start_in_run();
        test_start_held();
        test_stuck1();
        test_and();
        test_reset_mid_run();
        test_wide_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
